adc_init_sequencer: RTL and testbench

- Command sequencer for the ADS131A0X front end. Drives the word-level SPI master through a valid/ready transmit and receive-pulse interface.
- Runs the ADC power-up sequence in this order: hardware reset, READY poll, UNLOCK, four WREG configuration writes, WAKEUP, LOCK.
- After LOCK it streams data frames on each DRDY falling edge and presents channel samples to downstream logic.
- Sits between the top-level control (start_init) and the SPI master.

---
 rtl/adc_init_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_adc_init_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_init_sequencer.sv
// ADS131A0x power-up command sequencer and DRDY-driven frame reader.
// Sits between top-level control and a word-level SPI master (valid/ready tx, pulsed rx).
module adc_init_sequencer #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned RESET_CYCLES = 20,
  parameter logic [15:0] READY_WORD   = 16'hFF04,
  parameter int unsigned POLL_LIMIT   = 64,
  parameter int unsigned RETRY_LIMIT  = 3,
  parameter int unsigned RX_TIMEOUT   = 4096
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        start_init,
  input  logic        drdy_n,
  input  logic [7:0]  cfg_a_sys,
  input  logic [7:0]  cfg_clk1,
  input  logic [7:0]  cfg_clk2,
  input  logic [7:0]  cfg_adc_ena,
  output logic        adc_reset_n,
  output logic        tx_valid,
  output logic [15:0] tx_word,
  output logic        tx_last,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [15:0] rx_word,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [1:0]  sample_channel,
  output logic [15:0] status_word,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic        overrun,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HWRST  = 4'd1,
    ST_POLL   = 4'd2,
    ST_CMD    = 4'd3,
    ST_CHECK  = 4'd4,
    ST_STREAM = 4'd5,
    ST_ERROR  = 4'd6
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_READY = 3'd1,
    ERR_CMD   = 3'd2,
    ERR_RX    = 3'd3
  } err_t;

  localparam int unsigned RST_W   = $clog2(RESET_CYCLES + 1);
  localparam int unsigned POLL_W  = $clog2(POLL_LIMIT + 1);
  localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);
  localparam int unsigned TMO_W   = $clog2(RX_TIMEOUT + 1);
  localparam logic [2:0]  FRAME_WORDS = 3'(NUM_CHANNELS + 1);
  localparam logic [2:0]  LAST_IDX    = 3'd6;

  state_t              state_q, next_state;
  logic [RST_W-1:0]    rst_cnt_q;
  logic [POLL_W-1:0]   poll_cnt_q;
  logic [RETRY_W-1:0]  retry_cnt_q;
  logic [TMO_W-1:0]    tmo_cnt_q;
  logic [2:0]          idx_q;
  logic                busy_q;
  logic                tx_valid_q, tx_last_q;
  logic [15:0]         tx_word_q;
  logic                drdy_q;
  logic                frame_active_q;
  logic [2:0]          words_sent_q, words_rcvd_q;
  logic                adc_reset_n_q;
  logic                sample_valid_q;
  logic [15:0]         sample_data_q, status_word_q;
  logic [1:0]          sample_channel_q;
  err_t                error_code_q;
  logic                overrun_q;

  logic        accept, rx_evt, drdy_fall, link_idle, tmo_hit, start_ok;
  logic        launch, launch_last, set_error;
  logic [15:0] launch_word;
  err_t        error_next;
  logic [7:0]  wreg_addr, wreg_data;
  logic [15:0] cmd_word, cmd_expect;

  assign accept    = tx_valid_q & tx_ready;
  assign rx_evt    = rx_valid & busy_q;      // rx pulses with nothing outstanding are dropped
  assign drdy_fall = drdy_q & ~drdy_n;
  assign link_idle = ~tx_valid_q & ~busy_q;
  assign tmo_hit   = busy_q & ~rx_valid & (tmo_cnt_q == TMO_W'(RX_TIMEOUT - 1));
  assign start_ok  = start_init & ((state_q == ST_IDLE) | (state_q == ST_ERROR) |
                                   ((state_q == ST_STREAM) & ~frame_active_q & link_idle));

  // Command table: index 1..4 are WREG writes, the ADC echoes them with opcode 0x2000.
  always_comb begin
    wreg_addr  = 8'h0B;
    wreg_data  = cfg_a_sys;
    cmd_word   = 16'h0000;
    cmd_expect = 16'h0000;
    case (idx_q)
      3'd2:    begin wreg_addr = 8'h0D; wreg_data = cfg_clk1;    end
      3'd3:    begin wreg_addr = 8'h0E; wreg_data = cfg_clk2;    end
      3'd4:    begin wreg_addr = 8'h0F; wreg_data = cfg_adc_ena; end
      default: begin wreg_addr = 8'h0B; wreg_data = cfg_a_sys;   end
    endcase
    case (idx_q)
      3'd0:    begin cmd_word = 16'h0655; cmd_expect = 16'h0655; end
      3'd5:    begin cmd_word = 16'h0033; cmd_expect = 16'h0033; end
      3'd6:    begin cmd_word = 16'h0555; cmd_expect = 16'h0555; end
      default: begin
        cmd_word   = 16'h4000 | {wreg_addr, wreg_data};
        cmd_expect = 16'h2000 | {wreg_addr, wreg_data};
      end
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state  = state_q;
    launch      = 1'b0;
    launch_word = 16'h0000;
    launch_last = 1'b1;
    set_error   = 1'b0;
    error_next  = ERR_NONE;
    if (start_ok) begin
      next_state = ST_HWRST;
    end else if (tmo_hit) begin
      next_state = ST_ERROR;
      set_error  = 1'b1;
      error_next = ERR_RX;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_HWRST: if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) next_state = ST_POLL;
        ST_POLL: begin
          launch = link_idle;
          if (rx_evt) begin
            if (rx_word == READY_WORD) begin
              next_state = ST_CMD;
            end else if (poll_cnt_q == POLL_W'(POLL_LIMIT - 1)) begin
              next_state = ST_ERROR;
              set_error  = 1'b1;
              error_next = ERR_READY;
            end
          end
        end
        ST_CMD: begin
          launch      = link_idle;
          launch_word = cmd_word;
          if (rx_evt) next_state = ST_CHECK;
        end
        ST_CHECK: begin
          // The NULL here clocks out the response to the command sent in CMD.
          launch = link_idle;
          if (rx_evt) begin
            if (rx_word == cmd_expect) begin
              next_state = (idx_q == LAST_IDX) ? ST_STREAM : ST_CMD;
            end else if (retry_cnt_q == RETRY_W'(RETRY_LIMIT)) begin
              next_state = ST_ERROR;
              set_error  = 1'b1;
              error_next = ERR_CMD;
            end else begin
              next_state = ST_CMD;
            end
          end
        end
        ST_STREAM: begin
          launch      = frame_active_q & link_idle & (words_sent_q != FRAME_WORDS);
          launch_last = (words_sent_q == FRAME_WORDS - 3'd1);
        end
        ST_ERROR: ;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge system_clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= next_state;
  end

  // Word handshake and RX timer.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      tx_valid_q <= 1'b0;
      tx_word_q  <= 16'h0000;
      tx_last_q  <= 1'b1;
      busy_q     <= 1'b0;
      tmo_cnt_q  <= '0;
    end else if (start_ok || next_state == ST_ERROR) begin
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      if (launch) begin
        tx_valid_q <= 1'b1;
        tx_word_q  <= launch_word;
        tx_last_q  <= launch_last;
      end else if (accept) begin
        tx_valid_q <= 1'b0;
        busy_q     <= 1'b1;
        tmo_cnt_q  <= '0;
      end
      if (rx_evt) busy_q <= 1'b0;
      else if (busy_q && tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Sequence counters, all saturating.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      rst_cnt_q     <= '0;
      poll_cnt_q    <= '0;
      retry_cnt_q   <= '0;
      idx_q         <= 3'd0;
      adc_reset_n_q <= 1'b1;
      error_code_q  <= ERR_NONE;
    end else begin
      adc_reset_n_q <= (next_state != ST_HWRST);
      if (state_q == ST_HWRST) begin
        if (rst_cnt_q != '1) rst_cnt_q <= rst_cnt_q + 1'b1;
      end else begin
        rst_cnt_q <= '0;
      end
      if (start_ok) begin
        poll_cnt_q   <= '0;
        retry_cnt_q  <= '0;
        idx_q        <= 3'd0;
        error_code_q <= ERR_NONE;
      end else begin
        if (set_error) error_code_q <= error_next;
        if (state_q == ST_POLL && rx_evt && rx_word != READY_WORD && poll_cnt_q != '1)
          poll_cnt_q <= poll_cnt_q + 1'b1;
        if (state_q == ST_CHECK && rx_evt) begin
          if (rx_word == cmd_expect) begin
            retry_cnt_q <= '0;
            if (idx_q != LAST_IDX) idx_q <= idx_q + 3'd1;
          end else if (retry_cnt_q != '1) begin
            retry_cnt_q <= retry_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  // Frame reader: word 0 is the status word, words 1..N are channel samples.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      drdy_q           <= 1'b1;
      frame_active_q   <= 1'b0;
      words_sent_q     <= 3'd0;
      words_rcvd_q     <= 3'd0;
      sample_valid_q   <= 1'b0;
      sample_data_q    <= 16'h0000;
      sample_channel_q <= 2'd0;
      status_word_q    <= 16'h0000;
      overrun_q        <= 1'b0;
    end else begin
      drdy_q         <= drdy_n;
      sample_valid_q <= 1'b0;
      if (start_ok) overrun_q <= 1'b0;
      if (state_q != ST_STREAM || next_state != ST_STREAM) begin
        frame_active_q <= 1'b0;
      end else begin
        if (drdy_fall) begin
          if (frame_active_q) begin
            overrun_q <= 1'b1;
          end else begin
            frame_active_q <= 1'b1;
            words_sent_q   <= 3'd0;
            words_rcvd_q   <= 3'd0;
          end
        end
        if (launch) words_sent_q <= words_sent_q + 3'd1;
        if (rx_evt) begin
          if (words_rcvd_q == 3'd0) begin
            status_word_q <= rx_word;
          end else begin
            sample_valid_q   <= 1'b1;
            sample_data_q    <= rx_word;
            sample_channel_q <= 2'(words_rcvd_q - 3'd1);
          end
          words_rcvd_q <= words_rcvd_q + 3'd1;
          if (words_rcvd_q == FRAME_WORDS - 3'd1) frame_active_q <= 1'b0;
        end
      end
    end
  end

  assign adc_reset_n    = adc_reset_n_q;
  assign tx_valid       = tx_valid_q;
  assign tx_word        = tx_word_q;
  assign tx_last        = tx_last_q;
  assign sample_valid   = sample_valid_q;
  assign sample_data    = sample_data_q;
  assign sample_channel = sample_channel_q;
  assign status_word    = status_word_q;
  assign init_done      = (state_q == ST_STREAM);
  assign init_error     = (state_q == ST_ERROR);
  assign error_code     = error_code_q;
  assign overrun        = overrun_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_adc_init_sequencer.sv
// Scoreboard bench for adc_init_sequencer: an ADC/SPI model answers words one frame late,
// expected tx words and samples are queued ahead and compared as the DUT produces them.
module tb_adc_init_sequencer;

  localparam int NCH = 4;
  localparam logic [3:0] S_IDLE = 4'd0, S_STREAM = 4'd5, S_ERROR = 4'd6;

  logic        system_clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_init = 1'b0;
  logic        drdy_n = 1'b1;
  logic [7:0]  cfg_a_sys = 8'h60, cfg_clk1 = 8'h08, cfg_clk2 = 8'h86, cfg_adc_ena = 8'h0F;
  logic        tx_ready = 1'b0, rx_valid = 1'b0;
  logic [15:0] rx_word = 16'h0000;
  logic        adc_reset_n, tx_valid, tx_last, sample_valid, init_done, init_error, overrun;
  logic [15:0] tx_word, sample_data, status_word;
  logic [1:0]  sample_channel;
  logic [2:0]  error_code;
  logic [3:0]  state_dbg;

  adc_init_sequencer dut (
    .system_clock(system_clock), .reset(reset), .start_init(start_init), .drdy_n(drdy_n),
    .cfg_a_sys(cfg_a_sys), .cfg_clk1(cfg_clk1), .cfg_clk2(cfg_clk2), .cfg_adc_ena(cfg_adc_ena),
    .adc_reset_n(adc_reset_n), .tx_valid(tx_valid), .tx_word(tx_word), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_word(rx_word),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_channel(sample_channel),
    .status_word(status_word), .init_done(init_done), .init_error(init_error),
    .error_code(error_code), .overrun(overrun), .state_dbg(state_dbg)
  );

  always #10 system_clock = ~system_clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues: {tx_last, tx_word} and {channel, data}.
  logic [16:0] exp_tx[$];
  logic [17:0] exp_smp[$];
  logic [15:0] frame_rsp[$];

  // ADC model state
  bit          model_en = 1'b1, mute = 1'b0, never_ready = 1'b0, in_stream = 1'b0;
  bit          pending = 1'b0, seen_cmd = 1'b0, saw_4e86 = 1'b0;
  int          ready_at = 3, bad_clk1 = 0, polls = 0, rsp_delay = 0;
  int          n_acc = 0, null_polls = 0, n_4d08 = 0;
  logic [15:0] prev_word = 16'h0000, resp = 16'h0000;

  task automatic reset_model();
    mute = 0; never_ready = 0; in_stream = 0; pending = 0; seen_cmd = 0; saw_4e86 = 0;
    ready_at = 1; bad_clk1 = 0; polls = 0; n_acc = 0; null_polls = 0; n_4d08 = 0;
    prev_word = 16'h0000;
    frame_rsp.delete();
  endtask

  task automatic accept_word(input logic [15:0] w, input logic l);
    logic [16:0] e;
    logic [15:0] r;
    n_acc++;
    check("tx_expected_pending", 32'(exp_tx.size() > 0), 32'd1);
    if (exp_tx.size() > 0) begin
      e = exp_tx.pop_front();
      check("tx_word_last", 32'({l, w}), 32'(e));
    end
    if (in_stream && frame_rsp.size() > 0) begin
      r = frame_rsp.pop_front();
    end else if (prev_word != 16'h0000) begin
      r = (prev_word[15:12] == 4'h4) ? ((prev_word & 16'h0FFF) | 16'h2000) : prev_word;
      if (prev_word == 16'h4D08 && bad_clk1 > 0) begin
        r = r ^ 16'h0001;
        bad_clk1--;
      end
    end else begin
      polls++;
      r = (!never_ready && polls >= ready_at) ? 16'hFF04 : 16'h0000;
    end
    if (w == 16'h0000 && !seen_cmd) null_polls++;
    if (w != 16'h0000) seen_cmd = 1;
    if (w == 16'h4D08) n_4d08++;
    if (w == 16'h4E86) saw_4e86 = 1;
    prev_word = w;
    resp = r;
    pending = 1;
    rsp_delay = 2;
  endtask

  // SPI master + ADC model, acting on the falling edge.
  initial begin
    forever begin
      @(negedge system_clock);
      if (model_en) begin
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        if (pending && !mute) begin
          if (rsp_delay == 0) begin
            rx_valid = 1'b1;
            rx_word  = resp;
            pending  = 0;
          end else begin
            rsp_delay--;
          end
        end
        if (tx_valid && !pending) begin
          tx_ready = 1'b1;
          accept_word(tx_word, tx_last);
        end
      end
    end
  end

  // Sample monitor
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge system_clock);
      if (sample_valid) begin
        check("sample_expected", 32'(exp_smp.size() > 0), 32'd1);
        if (exp_smp.size() > 0) begin
          e = exp_smp.pop_front();
          check("sample_ch_data", 32'({sample_channel, sample_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge system_clock);
    #1;
  endtask

  task automatic pulse_start();
    step(); start_init = 1'b1;
    step(); start_init = 1'b0;
  endtask

  task automatic drdy_fall();
    step(); drdy_n = 1'b1;
    step(); drdy_n = 1'b0;
  endtask

  task automatic push_null();
    exp_tx.push_back({1'b1, 16'h0000});
  endtask

  task automatic push_cmd(input logic [15:0] w);
    exp_tx.push_back({1'b1, w});
    push_null();
  endtask

  task automatic push_frame(input logic [15:0] status, input logic [15:0] unit);
    logic [15:0] d;
    frame_rsp.push_back(status);
    for (int k = 0; k <= NCH; k++) exp_tx.push_back({(k == NCH), 16'h0000});
    for (int c = 0; c < NCH; c++) begin
      d = 16'(unit * (c + 1));
      frame_rsp.push_back(d);
      exp_smp.push_back({2'(c), d});
    end
  endtask

  task automatic wait_state(input string tag, input logic [3:0] st, input int max);
    int n = 0;
    while (state_dbg !== st && n < max) begin step(); n++; end
    check(tag, 32'(state_dbg), 32'(st));
  endtask

  task automatic wait_frame(input string tag, input int max);
    int n = 0;
    while ((exp_smp.size() > 0 || exp_tx.size() > 0 || pending) && n < max) begin step(); n++; end
    step();
    check(tag, 32'(exp_smp.size() + exp_tx.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_adc_reset_n"}, 32'(adc_reset_n), 32'd1);
    check({p, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({p, "_tx_word"}, 32'(tx_word), 32'd0);
    check({p, "_tx_last"}, 32'(tx_last), 32'd1);
    check({p, "_sample"}, 32'({sample_valid, sample_channel, sample_data}), 32'd0);
    check({p, "_status_word"}, 32'(status_word), 32'd0);
    check({p, "_flags"}, 32'({init_done, init_error, error_code, overrun}), 32'd0);
    check({p, "_state"}, 32'(state_dbg), 32'(S_IDLE));
  endtask

  initial begin
    int n;
    repeat (4) step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Nominal bring-up: ready on 3rd poll, correct echoes.
    reset_model();
    ready_at = 3;
    repeat (3) push_null();
    push_cmd(16'h0655); push_cmd(16'h4B60); push_cmd(16'h4D08); push_cmd(16'h4E86);
    push_cmd(16'h4F0F); push_cmd(16'h0033); push_cmd(16'h0555);
    pulse_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!adc_reset_n) n++;
      step();
    end
    check("adc_reset_low_cycles", 32'(n), 32'd20);
    wait_state("reach_stream", S_STREAM, 3000);
    check("init_done", 32'(init_done), 32'd1);
    check("poll_count", 32'(null_polls), 32'd3);
    check("init_tx_drained", 32'(exp_tx.size()), 32'd0);

    // Frame 1
    in_stream = 1;
    push_frame(16'h2200, 16'h0011);
    drdy_fall();
    wait_frame("frame1_done", 500);
    check("frame1_status", 32'(status_word), 32'h2200);
    check("frame1_no_overrun", 32'(overrun), 32'd0);

    // Frame 2 with a second DRDY fall mid-frame
    push_frame(16'h2201, 16'h0101);
    n = n_acc;
    drdy_fall();
    for (int i = 0; i < 200 && n_acc < n + 2; i++) step();
    drdy_fall();
    wait_frame("frame2_done", 500);
    check("frame2_status", 32'(status_word), 32'h2201);
    check("frame2_overrun", 32'(overrun), 32'd1);

    // RX timeout: first frame word accepted, never answered
    mute = 1;
    exp_tx.push_back({1'b0, 16'h0000});
    drdy_fall();
    for (int i = 0; i < 200 && !pending; i++) step();
    n = 0;
    while (!init_error && n < 5000) begin step(); n++; end
    check("rx_timeout_window", 32'(n >= 4096 && n <= 4098), 32'd1);
    check("rx_timeout_code", 32'({init_error, error_code}), 32'({1'b1, 3'd3}));
    check("rx_timeout_tx_idle", 32'(tx_valid), 32'd0);

    // Ready timeout
    reset_model();
    exp_tx.delete();
    never_ready = 1;
    repeat (64) push_null();
    pulse_start();
    wait_state("ready_timeout_state", S_ERROR, 4000);
    check("ready_timeout_code", 32'(error_code), 32'd1);
    check("ready_timeout_polls", 32'(null_polls), 32'd64);
    n = 0;
    for (int i = 0; i < 50; i++) begin if (tx_valid) n++; step(); end
    check("ready_timeout_no_tx", 32'(n), 32'd0);
    check("ready_timeout_drained", 32'(exp_tx.size()), 32'd0);

    // CLK1 echo wrong on every try
    reset_model();
    bad_clk1 = 4;
    push_null();
    push_cmd(16'h0655); push_cmd(16'h4B60);
    repeat (4) push_cmd(16'h4D08);
    pulse_start();
    wait_state("cmd_error_state", S_ERROR, 3000);
    check("cmd_error_code", 32'(error_code), 32'd2);
    check("cmd_error_4d08_count", 32'(n_4d08), 32'd4);
    check("cmd_error_drained", 32'(exp_tx.size()), 32'd0);

    // CLK1 echo wrong once, then correct
    reset_model();
    bad_clk1 = 1;
    push_null();
    push_cmd(16'h0655); push_cmd(16'h4B60); push_cmd(16'h4D08); push_cmd(16'h4D08);
    push_cmd(16'h4E86); push_cmd(16'h4F0F); push_cmd(16'h0033); push_cmd(16'h0555);
    pulse_start();
    wait_state("retry_reach_stream", S_STREAM, 3000);
    check("retry_flags", 32'({init_done, error_code}), 32'({1'b1, 3'd0}));
    check("retry_4d08_count", 32'(n_4d08), 32'd2);
    check("retry_drained", 32'(exp_tx.size()), 32'd0);

    // Reset during the WREG to 0x0E
    reset = 1'b1; step(); reset = 1'b0; step();
    reset_model();
    push_null();
    push_cmd(16'h0655); push_cmd(16'h4B60); push_cmd(16'h4D08);
    exp_tx.push_back({1'b1, 16'h4E86});
    pulse_start();
    n = 0;
    while (!saw_4e86 && n < 3000) begin step(); n++; end
    check("saw_wreg_0e", 32'(saw_4e86), 32'd1);
    reset = 1'b1;
    model_en = 0;
    step();
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    pending = 0;
    check_reset_outputs("midrst");
    reset = 1'b0;
    step();
    rx_valid = 1'b1;
    rx_word = 16'h2E86;
    step();
    rx_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin if (tx_valid || sample_valid) n++; step(); end
    check("late_rx_no_activity", 32'(n), 32'd0);
    check("late_rx_state", 32'({state_dbg, status_word}), 32'({S_IDLE, 16'h0000}));
    check("midrst_drained", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
